// File: rtl/vip_matrix_gen_3x3.sv
// ---------------------------------------------------------------------------
// vip_matrix_gen_3x3
//
// Builds a 3x3 pixel neighbourhood from a raster-scan pixel stream, one
// window per valid input pixel. Two line buffers supply the two older rows.
// Per-row column shift registers supply the three columns. The window is
// bottom-right anchored: p33 is pixel (y,x) and p22 is pixel (y-1,x-1).
//
// Build option: MATRIX_EDGE_REPLICATE_EN
//   undefined - rows and columns outside the image are zero padded
//   defined   - rows and columns outside the image replicate the nearest
//               valid row or column
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   per_frame_vsync            frame sync, high for the whole frame
//   per_frame_href             line valid, high for the whole active line
//   per_frame_clken            pixel strobe, qualified by href
//   per_img_data               input pixel
//   matrix_frame_vsync/href    inputs delayed by the 2-cycle window latency
//   matrix_frame_clken         window valid strobe
//   matrix_p11..p13            top row (line y-2), left to right
//   matrix_p21..p23            middle row (line y-1)
//   matrix_p31..p33            bottom row (line y), p33 is the newest pixel
// ---------------------------------------------------------------------------
module vip_matrix_gen_3x3 #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_data,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33
);

    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int YW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [XW-1:0] X_END  = XW'(IMG_HDISP);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_VDISP - 1);

    // ---------------- counters and edge detection ----------------
    logic              href_q, vsync_q;
    logic              href_rise, href_fall, vsync_rise;
    logic [XW-1:0]     x_cnt_q, x_cnt_d, x_eff;
    logic [YW-1:0]     y_cnt_q, y_cnt_d, y_eff;
    logic              pix_ok;
    logic [AW-1:0]     addr;

    // The edge-cleared counters are bypassed combinationally so that a pixel
    // arriving on the very cycle href (or vsync) rises already sees x=0 (y=0).
    always_comb begin
        href_rise  = per_frame_href & ~href_q;
        href_fall  = ~per_frame_href & href_q;
        vsync_rise = per_frame_vsync & ~vsync_q;
        x_eff      = href_rise ? '0 : x_cnt_q;
        y_eff      = vsync_rise ? '0 : y_cnt_q;
        pix_ok     = per_frame_href & per_frame_clken & (x_eff < X_END);
        addr       = x_eff[AW-1:0];
        // x saturates at IMG_HDISP: every further pixel on the line is dropped.
        x_cnt_d    = pix_ok ? (x_eff + XW'(1)) : x_eff;
        y_cnt_d    = y_eff;
        if (!vsync_rise && href_fall && (y_cnt_q != Y_LAST)) begin
            y_cnt_d = y_cnt_q + YW'(1);
        end
    end

    // ---------------- line buffers (not reset, masked by y) ----------------
    logic [DATA_W-1:0] lb0_mem [IMG_HDISP];
    logic [DATA_W-1:0] lb1_mem [IMG_HDISP];
    logic [DATA_W-1:0] lb0_rd_q, lb1_rd_q;

    // Read-before-write: LB1 inherits the line that LB0 is about to lose.
    always_ff @(posedge clk) begin
        if (pix_ok) begin
            lb0_rd_q      <= lb0_mem[addr];
            lb1_rd_q      <= lb1_mem[addr];
            lb0_mem[addr] <= per_img_data;
            lb1_mem[addr] <= lb0_mem[addr];
        end
    end

    // ---------------- stage 1 ----------------
    logic              s1_valid_q, s1_vsync_q, s1_href_q;
    logic              s1_top0_q, s1_top1_q, s1_left0_q, s1_left1_q;
    logic [DATA_W-1:0] s1_pix_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_vsync_q <= 1'b0;
            s1_href_q  <= 1'b0;
            s1_top0_q  <= 1'b0;
            s1_top1_q  <= 1'b0;
            s1_left0_q <= 1'b0;
            s1_left1_q <= 1'b0;
            s1_pix_q   <= '0;
        end else begin
            href_q     <= per_frame_href;
            vsync_q    <= per_frame_vsync;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            s1_valid_q <= pix_ok;
            s1_vsync_q <= per_frame_vsync;
            s1_href_q  <= per_frame_href;
            if (pix_ok) begin
                s1_pix_q   <= per_img_data;
                s1_top0_q  <= (y_eff == '0);
                s1_top1_q  <= (y_eff == YW'(1));
                s1_left0_q <= (x_eff == '0);
                s1_left1_q <= (x_eff == XW'(1));
            end
        end
    end

    // ---------------- stage 2: column shift with border handling ----------
    logic [DATA_W-1:0] col_new [3];
    logic [DATA_W-1:0] p_q [3][3];
    logic [DATA_W-1:0] p_d [3][3];
    logic              m_vsync_q, m_href_q, m_clken_q;

    always_comb begin
        col_new[0] = lb1_rd_q;
        col_new[1] = lb0_rd_q;
        col_new[2] = s1_pix_q;
`ifdef MATRIX_EDGE_REPLICATE_EN
        if (s1_top0_q) begin
            col_new[0] = s1_pix_q;
            col_new[1] = s1_pix_q;
        end else if (s1_top1_q) begin
            col_new[0] = lb0_rd_q;
        end
`else
        if (s1_top0_q) begin
            col_new[0] = '0;
            col_new[1] = '0;
        end else if (s1_top1_q) begin
            col_new[0] = '0;
        end
`endif
        p_d = p_q;
        if (s1_valid_q) begin
            for (int r = 0; r < 3; r++) begin
                p_d[r][0] = p_q[r][1];
                p_d[r][1] = p_q[r][2];
                p_d[r][2] = col_new[r];
`ifdef MATRIX_EDGE_REPLICATE_EN
                if (s1_left0_q) begin
                    p_d[r][0] = col_new[r];
                    p_d[r][1] = col_new[r];
                end else if (s1_left1_q) begin
                    // column 2 after the shift is the old column 3 (x=0)
                    p_d[r][0] = p_q[r][2];
                end
`else
                if (s1_left0_q) begin
                    p_d[r][0] = '0;
                    p_d[r][1] = '0;
                end else if (s1_left1_q) begin
                    p_d[r][0] = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    p_q[r][c] <= '0;
                end
            end
            m_vsync_q <= 1'b0;
            m_href_q  <= 1'b0;
            m_clken_q <= 1'b0;
        end else begin
            p_q       <= p_d;
            m_vsync_q <= s1_vsync_q;
            m_href_q  <= s1_href_q;
            m_clken_q <= s1_valid_q;
        end
    end

    assign matrix_frame_vsync = m_vsync_q;
    assign matrix_frame_href  = m_href_q;
    assign matrix_frame_clken = m_clken_q;
    assign matrix_p11 = p_q[0][0];
    assign matrix_p12 = p_q[0][1];
    assign matrix_p13 = p_q[0][2];
    assign matrix_p21 = p_q[1][0];
    assign matrix_p22 = p_q[1][1];
    assign matrix_p23 = p_q[1][2];
    assign matrix_p31 = p_q[2][0];
    assign matrix_p32 = p_q[2][1];
    assign matrix_p33 = p_q[2][2];

endmodule

// File: tb/tb_vip_matrix_gen_3x3.sv
module tb_vip_matrix_gen_3x3;

    localparam int HD = 4;
    localparam int VD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs, hr, ck;
    logic [7:0] din;
    logic       m_vs, m_hr, m_ck;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    vip_matrix_gen_3x3 #(.IMG_HDISP(HD), .IMG_VDISP(VD), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
        .per_img_data(din),
        .matrix_frame_vsync(m_vs), .matrix_frame_href(m_hr), .matrix_frame_clken(m_ck),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [71:0] win;
    assign win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

    logic [71:0] cap_q[$];
    logic [71:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && m_ck) cap_q.push_back(win);
    end

    // reference model state: frame image as received, line/pixel position
    logic [7:0] img [0:15][0:7];
    logic [7:0] src [0:15][0:7];
    int  ml, mx;
    logic prev_h, prev_v;
    bit  drv_done;

    function automatic logic [71:0] ref_win(input int y, input int x);
        logic [71:0] w;
        int yy, xx;
        logic [7:0] px;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                yy = y - 2 + r;
                xx = x - 2 + c;
`ifdef MATRIX_EDGE_REPLICATE_EN
                if (yy < 0) yy = 0;
                if (xx < 0) xx = 0;
                px = img[yy][xx];
`else
                px = (yy < 0 || xx < 0) ? 8'h00 : img[yy][xx];
`endif
                w[71 - 8*(3*r + c) -: 8] = px;
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        ml = 0; mx = 0; prev_h = 1'b0; prev_v = 1'b0;
    endtask

    task automatic drive(input logic v, input logic h, input logic c, input logic [7:0] d);
        @(posedge clk);
        #1;
        vs = v; hr = h; ck = c; din = d;
        if (prev_h && !h) ml++;
        if (v && !prev_v) ml = 0;
        if (h && !prev_h) mx = 0;
        if (h && c) begin
            if (mx < HD) begin
                img[ml][mx] = d;
                exp_q.push_back(ref_win(ml, mx));
            end
            mx++;
        end
        prev_h = h;
        prev_v = v;
    endtask

    // gapped=1 inserts an idle clken cycle before every pixel
    task automatic send_frame(input int nl, input int np, input bit gapped);
        drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < np; x++) begin
                if (gapped) drive(1, 1, 0, 8'($urandom));
                drive(1, 1, 1, src[y][x]);
            end
            drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    endtask

    task automatic fill_random();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) src[y][x] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vs = 1'($urandom); hr = 1'($urandom); ck = 1'($urandom); din = 8'($urandom);
            @(negedge clk);
            total++;
            if ({m_vs, m_hr, m_ck, win} !== 75'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", i, {m_vs, m_hr, m_ck, win});
            end
        end
        @(posedge clk); #1;
        vs = 0; hr = 0; ck = 0; din = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ck = 1'($urandom); din = 8'($urandom);
            @(negedge clk);
            total++;
            if ({m_vs, m_hr, m_ck, win} !== 75'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h want=0", i, {m_vs, m_hr, m_ck, win});
            end
        end
        ck = 0;
        model_reset();
    endtask

    task automatic test_interior();
        logic [71:0] want;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) src[y][x] = 8'(16*y + x + 1);
        cap_q.delete(); exp_q.delete();
        send_frame(6, HD, 1'b0);  // 6 lines > VD exercises y saturation
        total++;
        if (cap_q.size() != exp_q.size() || cap_q.size() != 6*HD) begin
            bad++;
            $display("FAIL interior_count got=%0d want=%0d", cap_q.size(), 6*HD);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL interior_win idx=%0d got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
        want = 72'h01_02_03_11_12_13_21_22_23;
        total++;
        if (cap_q.size() < 11 || cap_q[10] !== want) begin
            bad++;
            $display("FAIL interior_y2x2 got=%h want=%h", (cap_q.size() > 10) ? cap_q[10] : 72'd0, want);
        end
    endtask

    task automatic test_corner();
        logic [71:0] w0, w1;
`ifdef MATRIX_EDGE_REPLICATE_EN
        w0 = {9{8'h01}};
        w1 = {3{24'h010102}};
`else
        w0 = 72'h01;
        w1 = 72'h000102;
`endif
        for (int x = 0; x < 8; x++) src[0][x] = 8'(x + 1);
        cap_q.delete(); exp_q.delete();
        send_frame(1, HD, 1'b0);
        total++;
        if (cap_q.size() < 2 || cap_q[0] !== w0) begin
            bad++;
            $display("FAIL corner_x0 got=%h want=%h", (cap_q.size() > 0) ? cap_q[0] : 72'd0, w0);
        end
        total++;
        if (cap_q.size() < 2 || cap_q[1] !== w1) begin
            bad++;
            $display("FAIL corner_x1 got=%h want=%h", (cap_q.size() > 1) ? cap_q[1] : 72'd0, w1);
        end
    endtask

    task automatic test_gapped();
        logic [71:0] ref1[$];
        int n;
        fill_random();
        cap_q.delete(); exp_q.delete();
        send_frame(4, HD, 1'b0);
        ref1 = cap_q;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL cont_win idx=%0d got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
        cap_q.delete(); exp_q.delete();
        drv_done = 1'b0;
        fork
            begin
                send_frame(4, HD, 1'b1);
                drv_done = 1'b1;
            end
            begin
                n = 0;
                while (!drv_done && n < 2000) begin
                    @(negedge clk);
                    n++;
                    if (!m_ck && cap_q.size() > 0) begin
                        total++;
                        if (win !== cap_q[$]) begin
                            bad++;
                            $display("FAIL gap_hold cyc=%0d got=%h want=%h", n, win, cap_q[$]);
                        end
                    end
                end
            end
        join
        total++;
        if (cap_q.size() != ref1.size() || cap_q.size() != 4*HD) begin
            bad++;
            $display("FAIL gap_count got=%0d want=%0d", cap_q.size(), 4*HD);
        end
        for (int i = 0; i < cap_q.size() && i < ref1.size(); i++) begin
            total++;
            if (cap_q[i] !== ref1[i] || cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL gap_win idx=%0d got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic hv [0:2047];
        logic hh [0:2047];
        int n, strobes;
        fill_random();
        cap_q.delete(); exp_q.delete();
        drv_done = 1'b0;
        strobes = 0;
        fork
            begin
                drive(0, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
                for (int y = 0; y < 2; y++) begin
                    for (int x = 0; x < 6; x++) drive(1, 1, 1, src[y][x]);
                    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
                end
                drive(1, 0, 1, 8'hAA); drive(1, 0, 1, 8'h55);  // clken without href
                drive(1, 0, 0, 0);
                for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
                drv_done = 1'b1;
            end
            begin
                n = 0;
                while (!drv_done && n < 2000) begin
                    @(negedge clk);
                    hv[n] = vs;
                    hh[n] = hr;
                    if (m_ck) strobes++;
                    if (n >= 2) begin
                        total++;
                        if (m_vs !== hv[n-2] || m_hr !== hh[n-2]) begin
                            bad++;
                            $display("FAIL sync_lag cyc=%0d got=%b%b want=%b%b", n, m_vs, m_hr, hv[n-2], hh[n-2]);
                        end
                    end
                    n++;
                end
            end
        join
        total++;
        if (strobes != 2*HD) begin
            bad++;
            $display("FAIL ovf_strobes got=%0d want=%0d", strobes, 2*HD);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL ovf_win idx=%0d got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] top_want;
        fill_random();
        cap_q.delete(); exp_q.delete();
        drive(0, 0, 0, 0); drive(1, 0, 0, 0);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < HD; x++) drive(1, 1, 1, src[y][x]);
            drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        end
        drive(1, 1, 1, src[2][0]);
        drive(1, 1, 1, src[2][1]);
        @(posedge clk); #3;
        rst_n = 1'b0;
        vs = 0; hr = 0; ck = 0; din = 0;
        #1;
        total++;
        if ({m_vs, m_hr, m_ck, win} !== 75'd0) begin
            bad++;
            $display("FAIL midrst_clear got=%h want=0", {m_vs, m_hr, m_ck, win});
        end
        cap_q.delete(); exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        send_frame(3, HD, 1'b0);
        total++;
        if (cap_q.size() != 3*HD) begin
            bad++;
            $display("FAIL midrst_count got=%0d want=%0d", cap_q.size(), 3*HD);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midrst_win idx=%0d got=%h want=%h", i, cap_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < HD && i < cap_q.size(); i++) begin
`ifdef MATRIX_EDGE_REPLICATE_EN
            top_want = {cap_q[i][23:0], cap_q[i][23:0]};
`else
            top_want = 48'd0;
`endif
            total++;
            if (cap_q[i][71:24] !== top_want) begin
                bad++;
                $display("FAIL midrst_top idx=%0d got=%h want=%h", i, cap_q[i][71:24], top_want);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vs = 0; hr = 0; ck = 0; din = 0; rst_n = 1'b0;
        model_reset();
        test_reset();
        test_interior();
        test_corner();
        test_gapped();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
